slt_seq_n_bit: RTL and testbench
================================

Name: slt_seq_n_bit

Overview:
Sequential, parametrised successor to the combinational set-less-than unit. It compares two word_size operands one slice per clock, starting at the most significant slice, and supports both signed and unsigned modes. It produces SLT_out and EQ_out with a start/busy/done handshake. It sits beside the ALU/register file and gives a low-area comparator for wide words where a full-width subtractor is too costly.

Parameters:
word_size, 32, operand width in bits
slice_size, 8, bits compared per cycle; must divide word_size exactly; N = word_size/slice_size slices

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only while busy=0
mode_signed  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start
R2  input  word_size  left operand; sampled with start
R3  input  word_size  right operand; sampled with start
busy  output  1  high from the cycle after accept through the DONE cycle
done  output  1  one-cycle pulse; results valid in that cycle
SLT_out  output  1  1 when R2 < R3 under the sampled mode
EQ_out  output  1  1 when R2 == R3

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, SLT_out and EQ_out all 0; internal operand registers and slice index cleared. Reset asserted mid-operation aborts the compare; no done is issued.
- States:
  - IDLE -> CMP on start=1 (accept edge).
  - CMP -> CMP while slices remain.
  - CMP -> DONE when the decision is made.
  - DONE -> IDLE unconditionally after one cycle.
- Accept: latch R2 and R3. If mode_signed=1, invert bit word_size-1 of both latched operands; an unsigned compare is then correct for both modes. Load slice index = N-1.
- CMP cycle, for slice i = bits [i*slice_size +: slice_size]:
  - a<b: record lt=1, eq=0.
  - a>b: record lt=0, eq=0.
  - equal: keep eq=1.
  - Then decrement i.
  - After slice 0 with all slices equal: lt=0, eq=1.
  - Once a slice differs, lower slices never change the recorded result.
- DONE: done=1, busy=1. SLT_out and EQ_out update on the DONE entry edge and hold until the next accepted start completes. They are not cleared on accept.
- Latency: with C CMP cycles, done is high in cycle k+C+1 after accept edge k. The next start can be accepted in the following IDLE cycle, so the minimum issue interval is C+2 cycles.
- start while busy=1 (CMP or DONE) is ignored and not queued. Operand or mode changes after accept have no effect.
- N=1 is legal: a single CMP cycle.

Optional Feature:
SLT_EARLY_EXIT_EN
- Defined: CMP -> DONE on the first differing slice, so C = (N - index of first differing slice from the top). C = N when the operands are equal. Latency is data-dependent.
- Undefined: C = N always (constant latency). The result is identical in both builds; only timing differs.

Test Plan:
Configuration for all scenarios: word_size=32, slice_size=8, so N=4.
1. Unsigned R2=0x00000005, R3=0x00000007 -> SLT_out=1, EQ_out=0. First difference is in slice 0, so C=4 in both builds; done at k+5.
2. R2=0xFFFFFFFF, R3=0x00000001:
   - signed -> SLT_out=1.
   - unsigned -> SLT_out=0.
   - Early exit: C=1, done at k+2. Without early exit: done at k+5.
3. R2=R3=0x80000000, both modes -> SLT_out=0, EQ_out=1, done at k+5 in both builds.
4. R2=0x7FFFFFFF, R3=0x80000000:
   - signed -> SLT_out=0.
   - unsigned -> SLT_out=1.
   - EQ_out=0 in both modes.
5. start pulsed again during CMP with different operands -> ignored; the first result is reported. Then rst_n=0 mid-CMP -> busy, done, SLT_out and EQ_out are 0 immediately (async), and no done pulse follows.
6. start held at 1 continuously, with operands alternating between cases 1 and 3 -> back-to-back compares. Each done is followed by one IDLE cycle, and results alternate correctly.

Source files
------------

// File: rtl/slt_seq_n_bit.sv
// Sequential set-less-than / equality comparator: one slice per clock, MSB slice first.
// Optional build macro SLT_EARLY_EXIT_EN finishes on the first differing slice.
module slt_seq_n_bit #(
  parameter int word_size  = 32,
  parameter int slice_size = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode_signed,
  input  logic [word_size-1:0] R2,
  input  logic [word_size-1:0] R3,
  output logic                 busy,
  output logic                 done,
  output logic                 SLT_out,
  output logic                 EQ_out
);

  localparam int N     = word_size / slice_size;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [word_size-1:0] MSB_MASK = {1'b1, {(word_size-1){1'b0}}};

`ifdef SLT_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [word_size-1:0] a_q, a_d;
  logic [word_size-1:0] b_q, b_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 lt_q, lt_d;
  logic                 eq_q, eq_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 slt_q, slt_d;
  logic                 eqo_q, eqo_d;

  int                    shamt;
  logic [slice_size-1:0] sa, sb;
  logic                  step_lt, step_eq;

  always_comb begin
    shamt = int'(idx_q) * slice_size;
    sa    = slice_size'(a_q >> shamt);
    sb    = slice_size'(b_q >> shamt);

    // Only the first differing slice from the top may decide the result.
    step_lt = lt_q;
    step_eq = eq_q;
    if (eq_q && (sa < sb)) begin
      step_lt = 1'b1;
      step_eq = 1'b0;
    end else if (eq_q && (sa > sb)) begin
      step_lt = 1'b0;
      step_eq = 1'b0;
    end

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    slt_d   = slt_q;
    eqo_d   = eqo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Flipping both sign bits turns a signed compare into an unsigned one.
          a_d     = R2 ^ (mode_signed ? MSB_MASK : '0);
          b_d     = R3 ^ (mode_signed ? MSB_MASK : '0);
          idx_d   = IDX_W'(N - 1);
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = CMP;
        end
      end
      CMP: begin
        lt_d  = step_lt;
        eq_d  = step_eq;
        idx_d = idx_q - IDX_W'(1);
        if ((idx_q == '0) || (EARLY_EXIT && !step_eq)) begin
          state_d = DONE;
          done_d  = 1'b1;
          slt_d   = step_lt;
          eqo_d   = step_eq;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      slt_q   <= 1'b0;
      eqo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      slt_q   <= slt_d;
      eqo_q   <= eqo_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign SLT_out = slt_q;
  assign EQ_out  = eqo_q;

endmodule

// File: tb/tb_slt_seq_n_bit.sv
// Bench for slt_seq_n_bit (word_size=32, slice_size=8): vector table, random
// vectors against a behavioural model, and hand-written handshake/reset sequences.
module tb_slt_seq_n_bit;

  localparam int W  = 32;
  localparam int SL = 8;
  localparam int N  = W / SL;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         mode_signed;
  logic [W-1:0] R2, R3;
  logic         busy, done, SLT_out, EQ_out;

  int total = 0;
  int bad   = 0;

  slt_seq_n_bit #(.word_size(W), .slice_size(SL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mode_signed(mode_signed),
    .R2         (R2),
    .R3         (R3),
    .busy       (busy),
    .done       (done),
    .SLT_out    (SLT_out),
    .EQ_out     (EQ_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r2;
    logic [W-1:0] r3;
    logic         ms;
    logic         slt;
    logic         eq;
    int           c_early;
    int           c_full;
  } vec_t;

  vec_t tv[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Reference: result from plain integer comparison, latency from the first differing slice.
  function automatic logic model_slt(input logic [W-1:0] a, input logic [W-1:0] b, input logic ms);
    if (ms) return ($signed(a) < $signed(b));
    return (a < b);
  endfunction

  function automatic int model_c(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SLT_EARLY_EXIT_EN
    logic [W-1:0] d;
    d = a ^ b;
    for (int i = N - 1; i >= 0; i--)
      if (((d >> (i * SL)) & 32'hFF) != 0) return N - i;
    return N;
`else
    return N;
`endif
  endfunction

  function automatic int pick_c(input vec_t v);
`ifdef SLT_EARLY_EXIT_EN
    return v.c_early;
`else
    return v.c_full;
`endif
  endfunction

  task automatic wait_done(output int cnt, output bit busy_ok);
    cnt     = 0;
    busy_ok = 1'b1;
    while (cnt < 64) begin
      @(negedge clk);
      cnt++;
      if (!busy) busy_ok = 1'b0;
      if (done) break;
    end
  endtask

  task automatic run_cmp(input string nm, input logic [W-1:0] r2, input logic [W-1:0] r3,
                         input logic ms, input logic slt_e, input logic eq_e, input int c_e);
    int cnt;
    bit bok;
    @(negedge clk);
    R2 = r2; R3 = r3; mode_signed = ms; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    R2 = ~r2; R3 = $urandom; mode_signed = ~ms;
    wait_done(cnt, bok);
    check({nm, "_done_seen"}, done, 1);
    check({nm, "_latency"}, cnt, c_e + 1);
    check({nm, "_busy"}, bok, 1);
    check({nm, "_slt"}, SLT_out, slt_e);
    check({nm, "_eq"}, EQ_out, eq_e);
    @(negedge clk);
    check({nm, "_idle"}, {busy, done}, 2'b00);
    check({nm, "_hold"}, {SLT_out, EQ_out}, {slt_e, eq_e});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int cnt;
    bit bok;
    bit seen;
    logic [W-1:0] r2, r3, topmask;
    logic ms;
    int nd;

    tv[0] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 1'b0, 4, 4};
    tv[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0, 1, 4};
    tv[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1, 4};
    tv[3] = '{32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, 4, 4};
    tv[4] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 4, 4};
    tv[5] = '{32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b0, 1, 4};
    tv[6] = '{32'h7FFFFFFF, 32'h80000000, 1'b0, 1'b1, 1'b0, 1, 4};
    tv[7] = '{32'h12340000, 32'h12350000, 1'b0, 1'b1, 1'b0, 2, 4};
    tv[8] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 4, 4};
    tv[9] = '{32'h00AB0000, 32'h00AA0000, 1'b1, 1'b0, 1'b0, 2, 4};

    rst_n = 1'b0; start = 1'b0; mode_signed = 1'b0; R2 = '0; R3 = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {busy, done, SLT_out, EQ_out}, 4'b0000);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {busy, done}, 2'b00);

    for (int i = 0; i < 10; i++)
      run_cmp($sformatf("vec%0d", i), tv[i].r2, tv[i].r3, tv[i].ms, tv[i].slt, tv[i].eq, pick_c(tv[i]));

    for (int i = 0; i < 60; i++) begin
      r2 = $urandom;
      nd = $urandom_range(0, 4);
      topmask = (nd == 0) ? 32'h0 : (32'hFFFFFFFF << (W - SL * nd));
      r3 = (r2 & topmask) | ($urandom & ~topmask);
      ms = 1'($urandom_range(0, 1));
      run_cmp($sformatf("rnd%0d", i), r2, r3, ms, model_slt(r2, r3, ms), (r2 == r3), model_c(r2, r3));
    end

    // start re-asserted during CMP and DONE with other operands must be ignored
    @(negedge clk);
    R2 = 32'h5; R3 = 32'h7; mode_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("ign_busy", busy, 1);
    R2 = 32'h7; R3 = 32'h5; start = 1'b1;
    cnt = 1;
    while (!done && cnt < 64) begin
      @(negedge clk);
      cnt++;
    end
    check("ign_latency", cnt, 5);
    check("ign_slt", SLT_out, 1);
    check("ign_eq", EQ_out, 0);
    @(negedge clk);
    start = 1'b0;
    check("ign_idle", busy, 0);
    @(negedge clk);
    check("ign_not_queued", {busy, done}, 2'b00);

    // async reset in the middle of a compare
    @(negedge clk);
    R2 = 32'h80000000; R3 = 32'h80000000; mode_signed = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy, done, SLT_out, EQ_out}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", seen, 0);
    run_cmp("after_abort", 32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, N);

    // start held high: back-to-back compares alternating operand sets
    @(negedge clk);
    R2 = tv[0].r2; R3 = tv[0].r3; mode_signed = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 6; j++) begin
      wait_done(cnt, bok);
      check($sformatf("b2b%0d_latency", j), cnt, pick_c(tv[(j % 2) * 4]) + 1);
      check($sformatf("b2b%0d_busy", j), bok, 1);
      check($sformatf("b2b%0d_res", j), {SLT_out, EQ_out},
            {tv[(j % 2) * 4].slt, tv[(j % 2) * 4].eq});
      R2 = tv[((j + 1) % 2) * 4].r2;
      R3 = tv[((j + 1) % 2) * 4].r3;
      @(negedge clk);
      if (j == 5) start = 1'b0;
      check($sformatf("b2b%0d_idle", j), {busy, done}, 2'b00);
    end
    @(negedge clk);
    check("b2b_stopped", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
